// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between requesters A/B and a zeroing sweep of regs 1..31.
// Write outputs are registered one cycle after the handshake; Ready stays low while sweeping or when Start_Clear is high.
module regfile_write_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA_Valid,
  input  logic [4:0]  ReqA_Addr,
  input  logic [31:0] ReqA_Data,
  output logic        ReqA_Ready,
  input  logic        ReqB_Valid,
  input  logic [4:0]  ReqB_Addr,
  input  logic [31:0] ReqB_Data,
  output logic        ReqB_Ready,
  input  logic        Start_Clear,
  output logic        Busy,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [15:0] WriteCount
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  clr_addr_q, clr_addr_d;
  logic        ptr_q, ptr_d;  // 0 favours A, 1 favours B when both are valid
  logic        reg_write_q, reg_write_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  logic        grant_a, grant_b, run_open;
  logic        hs_a, hs_b;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign grant_a  = ReqA_Valid & (~ReqB_Valid | ~ptr_q);
  assign grant_b  = ReqB_Valid & (~ReqA_Valid |  ptr_q);
  assign run_open = (state_q == ST_RUN) & ~Start_Clear;

  assign ReqA_Ready = run_open & grant_a;
  assign ReqB_Ready = run_open & grant_b;

  assign hs_a     = ReqA_Valid & ReqA_Ready;
  assign hs_b     = ReqB_Valid & ReqB_Ready;
  assign sel_addr = hs_a ? ReqA_Addr : ReqB_Addr;
  assign sel_data = hs_a ? ReqA_Data : ReqB_Data;

  assign Busy          = (state_q == ST_CLEAR);
  assign RegWrite      = reg_write_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign WriteCount    = wr_cnt_q;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ptr_d       = ptr_q;
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        reg_write_d = 1'b1;
        wr_reg_d    = clr_addr_q;
        wr_data_d   = 32'd0;
        clr_addr_d  = clr_addr_q + 5'd1;
        if (clr_addr_q == 5'd31) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Start_Clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = 5'd1;
        end else if (hs_a | hs_b) begin
          ptr_d = hs_a;
          // Writes to register 0 are accepted but never reach the register file.
          if (sel_addr != 5'd0) begin
            reg_write_d = 1'b1;
            wr_reg_d    = sel_addr;
            wr_data_d   = sel_data;
            if (wr_cnt_q != 16'hFFFF) begin
              wr_cnt_d = wr_cnt_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= 5'd1;
      ptr_q       <= 1'b0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= 5'd0;
      wr_data_q   <= 32'd0;
      wr_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ptr_q       <= ptr_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqA_Valid = 1'b0, ReqB_Valid = 1'b0, Start_Clear = 1'b0;
  logic [4:0]  ReqA_Addr = '0, ReqB_Addr = '0;
  logic [31:0] ReqA_Data = '0, ReqB_Data = '0;
  logic        ReqA_Ready, ReqB_Ready, Busy, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [15:0] WriteCount;

  always #5 Clk = ~Clk;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA_Valid(ReqA_Valid), .ReqA_Addr(ReqA_Addr), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid), .ReqB_Addr(ReqB_Addr), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
    .Start_Clear(Start_Clear), .Busy(Busy),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite), .WriteCount(WriteCount)
  );

  // Register file fed by the DUT write port.
  logic [31:0] rf [32] = '{default: 32'hA5A5_5A5A};
  always @(posedge Clk) begin
    if (RegWrite) rf[WriteRegister] <= WriteData;
  end

  // Behavioural model state.
  int          sweep_left;
  bit          prefer_b;
  bit          e_rw;
  int          e_wr;
  logic [31:0] e_wd;
  int          e_cnt;
  logic [31:0] m_rf [32] = '{default: 32'hA5A5_5A5A};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sweep_left = 31;
    prefer_b   = 1'b0;
    e_rw       = 1'b0;
    e_wr       = 0;
    e_wd       = 32'd0;
    e_cnt      = 0;
  endtask

  // 0 = nobody, 1 = A, 2 = B
  function automatic int model_grant();
    if (Reset || sweep_left > 0 || Start_Clear) return 0;
    if (ReqA_Valid && ReqB_Valid) return prefer_b ? 2 : 1;
    if (ReqA_Valid) return 1;
    if (ReqB_Valid) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int g;
    int addr;
    g = model_grant();
    if (e_rw) m_rf[e_wr] = e_wd;
    if (Reset) begin
      model_reset();
    end else if (sweep_left > 0) begin
      e_rw = 1'b1;
      e_wr = 32 - sweep_left;
      e_wd = 32'd0;
      sweep_left--;
    end else if (Start_Clear) begin
      sweep_left = 31;
      e_rw = 1'b0;
    end else if (g != 0) begin
      prefer_b = (g == 1);
      addr = (g == 1) ? int'(ReqA_Addr) : int'(ReqB_Addr);
      if (addr != 0) begin
        e_rw = 1'b1;
        e_wr = addr;
        e_wd = (g == 1) ? ReqA_Data : ReqB_Data;
        if (e_cnt < 65535) e_cnt++;
      end else begin
        e_rw = 1'b0;
      end
    end else begin
      e_rw = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_RegWrite"}, 32'(RegWrite), 32'(e_rw));
    chk({ph, "_WriteRegister"}, 32'(WriteRegister), e_wr);
    chk({ph, "_WriteData"}, WriteData, e_wd);
    chk({ph, "_WriteCount"}, 32'(WriteCount), e_cnt);
  endtask

  task automatic step(input bit rst, input bit sc,
                      input bit va, input logic [4:0] aa, input logic [31:0] da,
                      input bit vb, input logic [4:0] ab, input logic [31:0] db,
                      output int g);
    @(negedge Clk);
    Reset = rst; Start_Clear = sc;
    ReqA_Valid = va; ReqA_Addr = aa; ReqA_Data = da;
    ReqB_Valid = vb; ReqB_Addr = ab; ReqB_Data = db;
    if (rst) model_reset();
    #1;
    g = model_grant();
    chk("ReqA_Ready", 32'(ReqA_Ready), 32'(g == 1));
    chk("ReqB_Ready", 32'(ReqB_Ready), 32'(g == 2));
    chk("Busy", 32'(Busy), 32'(sweep_left > 0));
    check_outputs("pre");
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs("post");
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_reg%0d", tag, i), rf[i], m_rf[i]);
  endtask

  initial begin
    int g;
    bit pa, pb, sc;
    logic [4:0]  qa, qb;
    logic [31:0] qda, qdb;

    model_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);

    // Power-up sweep, then one idle cycle so the last clear write lands.
    idle(31);
    idle(1);
    check_rf("sweep");

    step(1'b0, 1'b0, 1'b1, 5'd5, 32'd42, 1'b0, 5'd0, 32'd0, g);
    idle(2);
    chk("reg5_value", rf[5], 32'd42);
    chk("count_after_first", 32'(WriteCount), 32'd1);

    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd3410, g);
    idle(1);
    chk("reg0_untouched", rf[0], 32'hA5A5_5A5A);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 5'd2, 32'd15, 1'b1, 5'd3, 32'hFFFF_FFFF, g);
    idle(2);
    chk("reg2_value", rf[2], 32'd15);
    chk("reg3_value", rf[3], 32'hFFFF_FFFF);

    // Start_Clear with A waiting: A must wait out the whole sweep.
    step(1'b0, 1'b1, 1'b1, 5'd7, 32'd99, 1'b0, 5'd0, 32'd0, g);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 5'd7, 32'd99, 1'b0, 5'd0, 32'd0, g);
    idle(2);
    chk("reg7_after_clear", rf[7], 32'd99);
    check_rf("after_clear");

    // Random traffic; each requester holds its request until accepted.
    pa = 0; pb = 0; qa = '0; qb = '0; qda = '0; qdb = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa && $urandom_range(1, 0) == 1) begin
        pa = 1; qa = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)); qda = $urandom;
      end
      if (!pb && $urandom_range(1, 0) == 1) begin
        pb = 1; qb = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)); qdb = $urandom;
      end
      sc = ($urandom_range(99, 0) == 0);
      step(1'b0, sc, pa, qa, qda, pb, qb, qdb, g);
      if (g == 1) pa = 0;
      if (g == 2) pb = 0;
    end

    // Reset mid-sweep once ClrAddr has reached 17.
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
    idle(16);
    chk("sweep_reached_16", 32'(WriteRegister), 32'd16);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g);
    chk("restart_from_1", 32'(WriteRegister), 32'd1);
    idle(31);
    check_rf("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
